inst_cache: RTL and testbench

INST_CACHE -- requirements
Module: inst_cache

---
 rtl/inst_cache.sv | 108 ++++++++++
 tb/tb_inst_cache.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: zero-latency hits, blocking 4-word refill
// burst from a word-wide backing memory, flush-all and async reset.
module inst_cache #(
    parameter int LINE_NUM   = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_ren,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    output logic        inst_stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    localparam int IDX_W  = $clog2(LINE_NUM);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int TAG_W  = 32 - IDX_W - WORD_W - 2;
    localparam int LA_W   = TAG_W + IDX_W;

    typedef enum logic [1:0] {IDLE, REFILL, RESUME} state_t;
    state_t state, state_d;

    logic [LINE_NUM-1:0] valid;
    logic [TAG_W-1:0]    tag_mem  [LINE_NUM];
    logic [31:0]         data_mem [LINE_NUM][LINE_WORDS];

    logic [TAG_W-1:0]  a_tag;
    logic [IDX_W-1:0]  a_idx;
    logic [WORD_W-1:0] a_word;
    logic              unused_addr_bits;

    assign a_tag            = inst_addr[31 -: TAG_W];
    assign a_idx            = inst_addr[WORD_W+2 +: IDX_W];
    assign a_word           = inst_addr[2 +: WORD_W];
    assign unused_addr_bits = ^inst_addr[1:0];

    // miss_addr holds {tag, index} of the line being refilled
    logic [LA_W-1:0]   miss_addr;
    logic [TAG_W-1:0]  m_tag;
    logic [IDX_W-1:0]  m_idx;
    logic [WORD_W-1:0] cnt;
    logic              squash;
    logic              hit, lookup_miss, last_ack;

    assign m_tag = miss_addr[LA_W-1 -: TAG_W];
    assign m_idx = miss_addr[IDX_W-1:0];

    assign hit         = inst_ren & (state == IDLE) & valid[a_idx] & (tag_mem[a_idx] == a_tag);
    assign lookup_miss = inst_ren & (state == IDLE) & ~hit;
    assign last_ack    = (state == REFILL) & mem_ack & (cnt == WORD_W'(LINE_WORDS - 1));

    assign inst_data  = hit ? data_mem[a_idx][a_word] : '0;
    assign inst_stall = (inst_ren & ~hit) | (state != IDLE);
    assign mem_req    = (state == REFILL);
    assign mem_addr   = {miss_addr, cnt, 2'b00};

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (lookup_miss) state_d = REFILL;
            REFILL:  if (last_ack)    state_d = RESUME;
            RESUME:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            miss_addr <= '0;
            squash    <= 1'b0;
        end else begin
            state <= state_d;
            if (lookup_miss) begin
                miss_addr <= {a_tag, a_idx};
                cnt       <= '0;
                squash    <= 1'b0;
            end else if (state == REFILL) begin
                if (mem_ack) cnt <= cnt + WORD_W'(1);
                // a flush seen mid-burst keeps the refilled line from going valid
                if (flush)   squash <= 1'b1;
            end
        end
    end

    // flush has priority over the final-ack valid set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (lookup_miss) begin
            valid[a_idx] <= 1'b0;
        end else if (last_ack && !squash) begin
            valid[m_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == REFILL && mem_ack) data_mem[m_idx][cnt] <= mem_rdata;
        if (last_ack)                   tag_mem[m_idx]       <= m_tag;
    end
endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed vector table, hand-written
// flush/reset/slow-memory sequences, and random fetches against a line model.
module tb_inst_cache;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_ren = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_data;
    logic        inst_stall;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    inst_cache #(.LINE_NUM(16), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst), .inst_ren(inst_ren), .inst_addr(inst_addr),
        .inst_data(inst_data), .inst_stall(inst_stall), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int gap = 0;
    int wcnt = 0;
    logic [31:0] ackq[$];
    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

    // line model: which tag each index currently holds
    bit          mvalid[16];
    logic [23:0] mtag[16];

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        logic [31:0] data;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory returns its own word address as data; acks after 'gap' wait cycles
    always @(negedge clk) begin
        if (mem_req) begin
            if (prev_req && !prev_ack) chk("mem_addr_hold", mem_addr, prev_addr);
            if (wcnt == gap) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr;
                ackq.push_back(mem_addr);
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt = 0;
        end
        prev_req  = mem_req;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
    end

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mvalid[i] = 0;
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        return mvalid[a[7:4]] && (mtag[a[7:4]] == a[31:8]);
    endfunction

    task automatic do_fetch(input logic [31:0] addr, input bit exp_hit,
                            input logic [31:0] exp_data, input int flush_at, input string nm);
        int n;
        int exp_extra;
        bit fdone;
        logic [31:0] base;
        base  = addr & 32'hFFFF_FFF0;
        n     = 0;
        fdone = 0;
        exp_extra = (flush_at > 0) ? 8 * (gap + 1) + 3 : 4 * (gap + 1) + 1;
        ackq.delete();
        @(negedge clk);
        inst_ren  = 1'b1;
        inst_addr = addr;
        #1;
        if (exp_hit) begin
            chk($sformatf("%s hit_stall", nm), 32'(inst_stall), 32'd0);
            chk($sformatf("%s hit_data", nm), inst_data, exp_data);
        end else begin
            chk($sformatf("%s miss_stall", nm), 32'(inst_stall), 32'd1);
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                #1;
                if (flush) flush = 1'b0;
                if (!inst_stall) break;
                n++;
                if (flush_at > 0 && !fdone && ackq.size() == flush_at) begin
                    flush = 1'b1;
                    fdone = 1;
                end
            end
            chk($sformatf("%s stall_drop", nm), 32'(inst_stall), 32'd0);
            chk($sformatf("%s stall_cycles", nm), 32'(n), 32'(exp_extra));
            chk($sformatf("%s refill_data", nm), inst_data, exp_data);
            chk($sformatf("%s burst_len", nm), 32'(ackq.size()), (flush_at > 0) ? 32'd8 : 32'd4);
            foreach (ackq[k]) chk($sformatf("%s burst_addr%0d", nm, k), ackq[k], base + 32'(4 * (k % 4)));
            if (flush_at > 0) model_clear();
            mvalid[addr[7:4]] = 1;
            mtag[addr[7:4]]   = addr[31:8];
        end
        @(negedge clk);
        inst_ren = 1'b0;
        #1;
        chk($sformatf("%s idle_stall", nm), 32'(inst_stall), 32'd0);
        chk($sformatf("%s idle_data", nm), inst_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h0000_0104, 0, 32'h0000_0104};
        vecs[1]  = '{32'h0000_0100, 1, 32'h0000_0100};
        vecs[2]  = '{32'h0000_0104, 1, 32'h0000_0104};
        vecs[3]  = '{32'h0000_0108, 1, 32'h0000_0108};
        vecs[4]  = '{32'h0000_010C, 1, 32'h0000_010C};
        vecs[5]  = '{32'h0000_0114, 0, 32'h0000_0114};
        vecs[6]  = '{32'h0000_0118, 1, 32'h0000_0118};
        vecs[7]  = '{32'h0000_0204, 0, 32'h0000_0204};
        vecs[8]  = '{32'h0000_0208, 1, 32'h0000_0208};
        vecs[9]  = '{32'h0000_0104, 0, 32'h0000_0104};
        vecs[10] = '{32'h0000_010B, 1, 32'h0000_0108};
        vecs[11] = '{32'h0000_020C, 0, 32'h0000_020C};
        model_clear();

        // reset state, and cold lookup while held in reset
        #12;
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst stall_idle", 32'(inst_stall), 32'd0);
        chk("rst data_idle", inst_data, 32'd0);
        inst_ren = 1'b1;
        inst_addr = 32'h0000_0104;
        #1;
        chk("rst cold_stall", 32'(inst_stall), 32'd1);
        inst_ren = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) do_fetch(vecs[i].addr, vecs[i].hit, vecs[i].data, 0, $sformatf("vec%0d", i));

        // slow memory: ack every third cycle
        gap = 2;
        do_fetch(32'h0000_0408, 0, 32'h0000_0408, 0, "slow");
        gap = 0;

        // flush coincident with final ack: line stays invalid, refetch refills
        do_fetch(32'h0000_0300, 0, 32'h0000_0300, 4, "flush_last_ack");
        do_fetch(32'h0000_0118, 0, 32'h0000_0118, 0, "flushed_other");

        // flush in idle still returns the same-cycle hit
        @(negedge clk);
        inst_ren  = 1'b1;
        inst_addr = 32'h0000_0304;
        flush     = 1'b1;
        #1;
        chk("idle_flush hit_stall", 32'(inst_stall), 32'd0);
        chk("idle_flush hit_data", inst_data, 32'h0000_0304);
        @(negedge clk);
        flush    = 1'b0;
        inst_ren = 1'b0;
        model_clear();
        do_fetch(32'h0000_0304, 0, 32'h0000_0304, 0, "after_flush");

        // reset after second ack of a burst
        ackq.delete();
        @(negedge clk);
        inst_ren  = 1'b1;
        inst_addr = 32'h0000_0508;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (ackq.size() == 2) break;
        end
        chk("rst_mid acks_before", 32'(ackq.size()), 32'd2);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid mem_addr", mem_addr, 32'd0);
        chk("rst_mid cold_stall", 32'(inst_stall), 32'd1);
        inst_ren = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        do_fetch(32'h0000_0508, 0, 32'h0000_0508, 0, "rst_refetch");

        // random fetches against the line model
        for (int r = 0; r < 60; r++) begin
            logic [31:0] a;
            a = {22'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            gap = $urandom_range(0, 2);
            do_fetch(a, model_hit(a), a & 32'hFFFF_FFFC, 0, $sformatf("rnd%0d", r));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
